// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
// Runs ADS8528 capture windows. Each frame issues a one-cycle conversion-start
// pulse, collects NUM_CH channel words into the sample FIFO, then waits for the
// next sample tick. The window ends after CAPTURE_LEN frames, on a conversion
// timeout, or on abort. A drain path lets the SPI side read the FIFO at any time.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   start, abort      open a capture window / terminate it (abort wins)
//   adc_convst        one-cycle conversion start pulse
//   adc_data_valid,
//   adc_data          one channel word from the ADC driver
//   mem_full,
//   mem_empty,
//   mem_count         FIFO status inputs (mem_count is informational only)
//   mem_write,
//   mem_data          registered FIFO write port
//   spi_rd_req        SPI side wants the next word
//   mem_read          FIFO read strobe (request gated by empty)
//   spi_rd_valid      FIFO data_out valid, one cycle after mem_read
//   busy, done        window in progress / completed normally
//   overflow          sticky: a word was dropped on a full FIFO
//   timeout_err       sticky: a conversion came up short of NUM_CH words
//   frame_cnt         frames completed in the current or last window
module adc_capture_sequencer #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DEPTH        = 16384,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned SAMPLE_DIV   = 200,
    parameter int unsigned CONV_TIMEOUT = 64,
    parameter int unsigned CAPTURE_LEN  = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    output logic                             adc_convst,
    input  logic                             adc_data_valid,
    input  logic [DATA_WIDTH-1:0]            adc_data,
    input  logic                             mem_full,
    input  logic                             mem_empty,
    input  logic [$clog2(DEPTH)-1:0]         mem_count,
    output logic                             mem_write,
    output logic [DATA_WIDTH-1:0]            mem_data,
    input  logic                             spi_rd_req,
    output logic                             mem_read,
    output logic                             spi_rd_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic                             timeout_err,
    output logic [$clog2(CAPTURE_LEN+1)-1:0] frame_cnt
);

    localparam int unsigned CH_W  = $clog2(NUM_CH + 1);
    localparam int unsigned TO_W  = $clog2(CONV_TIMEOUT + 1);
    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
    localparam int unsigned FR_W  = $clog2(CAPTURE_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_COLLECT,
        S_WAIT_TICK,
        S_DONE
    } state_t;

    state_t                state_q;
    logic                  convst_q;
    logic                  mem_write_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  rd_valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  overflow_q;
    logic                  timeout_q;
    logic [FR_W-1:0]       frame_cnt_q;
    logic [DIV_W-1:0]      div_cnt_q;
    logic [TO_W-1:0]       to_cnt_q;
    logic [CH_W-1:0]       ch_cnt_q;

    logic word_in;
    logic frame_end;
    logic last_frame;
    logic to_expire;
    logic tick;
    logic launch;
    logic unused_mem_count;

    assign unused_mem_count = ^mem_count;

    assign word_in    = (state_q == S_COLLECT) && adc_data_valid;
    assign frame_end  = word_in && (ch_cnt_q == CH_W'(NUM_CH - 1));
    assign last_frame = (frame_cnt_q == FR_W'(CAPTURE_LEN - 1));
    // to_cnt counts cycles since the convst cycle, so expiry lands exactly
    // CONV_TIMEOUT cycles after the pulse.
    assign to_expire  = (to_cnt_q == TO_W'(CONV_TIMEOUT - 1));
    assign tick       = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
    assign launch     = start && !abort;

    // Drain path: held off during reset so every output reads zero.
    assign mem_read     = rst & spi_rd_req & ~mem_empty;
    assign spi_rd_valid = rd_valid_q;

    assign adc_convst  = convst_q;
    assign mem_write   = mem_write_q;
    assign mem_data    = mem_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;
    assign frame_cnt   = frame_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            convst_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_data_q  <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            frame_cnt_q <= '0;
            div_cnt_q   <= '0;
            to_cnt_q    <= '0;
            ch_cnt_q    <= '0;
        end else begin
            convst_q    <= 1'b0;
            mem_write_q <= 1'b0;
            rd_valid_q  <= mem_read;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state_q     <= S_CONVERT;
                        convst_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        frame_cnt_q <= '0;
                        overflow_q  <= 1'b0;
                        timeout_q   <= 1'b0;
                        div_cnt_q   <= '0;
                        to_cnt_q    <= '0;
                        ch_cnt_q    <= '0;
                    end
                end

                S_CONVERT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= S_COLLECT;
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                        to_cnt_q  <= to_cnt_q + TO_W'(1);
                    end
                end

                S_COLLECT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                        to_cnt_q  <= to_cnt_q + TO_W'(1);
                        if (word_in) begin
                            // A dropped word still advances ch_cnt to keep frames aligned.
                            if (mem_full) begin
                                overflow_q <= 1'b1;
                            end else begin
                                mem_write_q <= 1'b1;
                                mem_data_q  <= adc_data;
                            end
                            ch_cnt_q <= ch_cnt_q + CH_W'(1);
                        end
                        // A frame completing on its last allowed cycle beats the timeout.
                        if (frame_end) begin
                            if (frame_cnt_q != FR_W'(CAPTURE_LEN)) begin
                                frame_cnt_q <= frame_cnt_q + FR_W'(1);
                            end
                            if (last_frame) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_WAIT_TICK;
                            end
                        end else if (to_expire) begin
                            timeout_q <= 1'b1;
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end

                S_WAIT_TICK: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (tick) begin
                        state_q   <= S_CONVERT;
                        convst_q  <= 1'b1;
                        div_cnt_q <= '0;
                        to_cnt_q  <= '0;
                        ch_cnt_q  <= '0;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
module tb_adc_capture_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        adc_convst;
    logic        adc_data_valid = 1'b0;
    logic [15:0] adc_data = '0;
    logic        mem_full;
    logic        mem_empty;
    logic [3:0]  mem_count;
    logic        mem_write;
    logic [15:0] mem_data;
    logic        spi_rd_req;
    logic        mem_read;
    logic        spi_rd_valid;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        timeout_err;
    logic [1:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    // ADC driver model: after each convst, up to adc_words valids at +2,+4,+6,+8.
    int adc_k     = 15;
    int adc_words = 4;
    int adc_idx   = 0;

    adc_capture_sequencer #(
        .DATA_WIDTH  (16),
        .DEPTH       (16),
        .NUM_CH      (4),
        .SAMPLE_DIV  (20),
        .CONV_TIMEOUT(10),
        .CAPTURE_LEN (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .adc_convst    (adc_convst),
        .adc_data_valid(adc_data_valid),
        .adc_data      (adc_data),
        .mem_full      (mem_full),
        .mem_empty     (mem_empty),
        .mem_count     (mem_count),
        .mem_write     (mem_write),
        .mem_data      (mem_data),
        .spi_rd_req    (spi_rd_req),
        .mem_read      (mem_read),
        .spi_rd_valid  (spi_rd_valid),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .timeout_err   (timeout_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        adc_data_valid = 1'b0;
        if (adc_convst) adc_k = 0;
        else if (adc_k < 15) adc_k = adc_k + 1;
        if ((adc_k == 2 || adc_k == 4 || adc_k == 6 || adc_k == 8) && (adc_k / 2) <= adc_words) begin
            adc_data_valid = 1'b1;
            adc_data = 16'(32'hC000 + adc_idx);
            adc_idx = adc_idx + 1;
        end
    end

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; mem_full = 1'b0;
        mem_empty = 1'b1; mem_count = '0; spi_rd_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({adc_convst, mem_write, mem_read, spi_rd_valid, busy, done, overflow, timeout_err, frame_cnt, mem_data} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {adc_convst, mem_write, mem_read, spi_rd_valid, busy, done, overflow, timeout_err, frame_cnt, mem_data});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_capture();
        int base, nconv, nwr, done_at;
        int conv_at[4];
        int exp_conv[3] = '{1, 21, 41};
        logic [15:0] wr[16];
        @(negedge clk);
        base = adc_idx; nconv = 0; nwr = 0; done_at = 0;
        start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL cap_busy: got %b expected 1", busy); end
            end
            // start while busy must not disturb the convst schedule
            if (i == 30) start = 1'b1;
            if (i == 31) start = 1'b0;
            if (adc_convst) begin if (nconv < 4) conv_at[nconv] = i; nconv++; end
            if (mem_write) begin if (nwr < 16) wr[nwr] = mem_data; nwr++; end
            if (done) begin done_at = i; break; end
        end
        checks++;
        if (done_at != 50) begin errors++; $display("FAIL cap_done_cycle: got %0d expected 50", done_at); end
        checks++;
        if (nconv != 3) begin errors++; $display("FAIL cap_convst_count: got %0d expected 3", nconv); end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (j < nconv && conv_at[j] != exp_conv[j]) begin
                errors++; $display("FAIL cap_convst_cycle%0d: got %0d expected %0d", j, conv_at[j], exp_conv[j]);
            end
        end
        checks++;
        if (nwr != 12) begin errors++; $display("FAIL cap_write_count: got %0d expected 12", nwr); end
        for (int j = 0; j < 12 && j < nwr; j++) begin
            checks++;
            if (wr[j] !== 16'(32'hC000 + base + j)) begin
                errors++; $display("FAIL cap_data%0d: got %h expected %h", j, wr[j], 16'(32'hC000 + base + j));
            end
        end
        checks++;
        if ({frame_cnt, busy, overflow, timeout_err} !== {2'd3, 3'b000}) begin
            errors++; $display("FAIL cap_status: got frame_cnt=%0d busy=%b ovf=%b to=%b expected 3 0 0 0", frame_cnt, busy, overflow, timeout_err);
        end
    endtask

    task automatic test_overflow();
        int base, nwr, done_at, exp_idx;
        logic [15:0] wr[16];
        @(negedge clk);
        base = adc_idx; nwr = 0; done_at = 0;
        start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 21) mem_full = 1'b1;
            if (i == 41) mem_full = 1'b0;
            if (mem_write) begin if (nwr < 16) wr[nwr] = mem_data; nwr++; end
            if (done) begin done_at = i; break; end
        end
        checks++;
        if (done_at != 50) begin errors++; $display("FAIL ovf_done_cycle: got %0d expected 50", done_at); end
        checks++;
        if (nwr != 8) begin errors++; $display("FAIL ovf_write_count: got %0d expected 8", nwr); end
        for (int j = 0; j < 8 && j < nwr; j++) begin
            exp_idx = (j < 4) ? j : j + 4;
            checks++;
            if (wr[j] !== 16'(32'hC000 + base + exp_idx)) begin
                errors++; $display("FAIL ovf_data%0d: got %h expected %h", j, wr[j], 16'(32'hC000 + base + exp_idx));
            end
        end
        checks++;
        if ({overflow, frame_cnt, timeout_err} !== {1'b1, 2'd3, 1'b0}) begin
            errors++; $display("FAIL ovf_status: got ovf=%b frame_cnt=%0d to=%b expected 1 3 0", overflow, frame_cnt, timeout_err);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({overflow, done} !== 2'b11) begin errors++; $display("FAIL ovf_sticky: got ovf=%b done=%b expected 1 1", overflow, done); end
    endtask

    task automatic test_timeout();
        int nconv, nwr, done_at, extra;
        @(negedge clk);
        nconv = 0; nwr = 0; done_at = 0;
        start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                checks++;
                if (overflow !== 1'b0) begin errors++; $display("FAIL to_ovf_cleared: got %b expected 0", overflow); end
            end
            if (i == 12) adc_words = 3;
            if (adc_convst) nconv++;
            if (mem_write) nwr++;
            if (done) begin done_at = i; break; end
        end
        checks++;
        if (done_at != 31) begin errors++; $display("FAIL to_done_cycle: got %0d expected 31", done_at); end
        checks++;
        if ({timeout_err, frame_cnt, busy} !== {1'b1, 2'd1, 1'b0}) begin
            errors++; $display("FAIL to_status: got to=%b frame_cnt=%0d busy=%b expected 1 1 0", timeout_err, frame_cnt, busy);
        end
        checks++;
        if (nconv != 2 || nwr != 7) begin errors++; $display("FAIL to_counts: got convst=%0d writes=%0d expected 2 7", nconv, nwr); end
        extra = 0;
        repeat (30) begin @(negedge clk); if (adc_convst) extra++; end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL to_no_more_convst: got %0d expected 0", extra); end
        adc_words = 4;
    endtask

    task automatic test_abort();
        int nconv, nwr, nbusy;
        @(negedge clk);
        nconv = 0; nwr = 0;
        start = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                checks++;
                if ({adc_convst, done} !== 2'b10) begin errors++; $display("FAIL ab_launch: got convst=%b done=%b expected 1 0", adc_convst, done); end
            end
            if (i == 12) begin
                checks++;
                if ({busy, frame_cnt} !== {1'b1, 2'd1}) begin errors++; $display("FAIL ab_pre: got busy=%b frame_cnt=%0d expected 1 1", busy, frame_cnt); end
                abort = 1'b1;
            end
            if (i == 13) begin
                abort = 1'b0;
                checks++;
                if ({busy, done, frame_cnt} !== {2'b00, 2'd1}) begin
                    errors++; $display("FAIL ab_idle: got busy=%b done=%b frame_cnt=%0d expected 0 0 1", busy, done, frame_cnt);
                end
            end
            if (i > 1 && adc_convst) nconv++;
            if (i > 13 && mem_write) nwr++;
        end
        checks++;
        if (nconv != 0 || nwr != 0) begin errors++; $display("FAIL ab_quiet: got convst=%0d writes=%0d expected 0 0", nconv, nwr); end
        // start and abort together from IDLE: nothing may begin
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        nconv = 0; nbusy = 0;
        if (adc_convst) nconv++;
        if (busy) nbusy++;
        repeat (25) begin @(negedge clk); if (adc_convst) nconv++; if (busy) nbusy++; end
        checks++;
        if (nconv != 0 || nbusy != 0 || done !== 1'b0) begin
            errors++; $display("FAIL ab_start_blocked: got convst=%0d busy_cycles=%0d done=%b expected 0 0 0", nconv, nbusy, done);
        end
    endtask

    task automatic test_drain();
        logic [4:0] exp_rd = 5'b00011;
        logic [4:0] exp_v  = 5'b00110;
        int fcnt = 2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            spi_rd_req = (c < 4);
            mem_empty  = (fcnt == 0);
            #1;
            checks++;
            if (mem_read !== exp_rd[c]) begin errors++; $display("FAIL drain_read%0d: got %b expected %b", c, mem_read, exp_rd[c]); end
            checks++;
            if (spi_rd_valid !== exp_v[c]) begin errors++; $display("FAIL drain_valid%0d: got %b expected %b", c, spi_rd_valid, exp_v[c]); end
            if (mem_read === 1'b1) fcnt--;
        end
        spi_rd_req = 1'b0;
        mem_empty  = 1'b1;
    endtask

    task automatic test_async_reset();
        int base, nwr, nbusy, done_at;
        logic [15:0] wr[16];
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 4) begin spi_rd_req = 1'b1; mem_empty = 1'b0; end
        end
        checks++;
        if ({busy, spi_rd_valid, mem_read} !== 3'b111) begin
            errors++; $display("FAIL ar_pre: got busy=%b valid=%b read=%b expected 1 1 1", busy, spi_rd_valid, mem_read);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({adc_convst, mem_write, mem_read, spi_rd_valid, busy, done, overflow, timeout_err, frame_cnt, mem_data} !== 26'd0) begin
            errors++;
            $display("FAIL ar_outputs: got %h expected 0", {adc_convst, mem_write, mem_read, spi_rd_valid, busy, done, overflow, timeout_err, frame_cnt, mem_data});
        end
        spi_rd_req = 1'b0;
        mem_empty  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        nwr = 0; nbusy = 0;
        repeat (10) begin @(negedge clk); if (mem_write) nwr++; if (busy) nbusy++; end
        checks++;
        if (nwr != 0 || nbusy != 0) begin errors++; $display("FAIL ar_idle: got writes=%0d busy_cycles=%0d expected 0 0", nwr, nbusy); end
        @(negedge clk);
        base = adc_idx; nwr = 0; done_at = 0;
        start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (mem_write) begin if (nwr < 16) wr[nwr] = mem_data; nwr++; end
            if (done) begin done_at = i; break; end
        end
        checks++;
        if (done_at != 50 || nwr != 12) begin errors++; $display("FAIL ar_window: got done_at=%0d writes=%0d expected 50 12", done_at, nwr); end
        checks++;
        if (nwr > 0 && (wr[0] !== 16'(32'hC000 + base) || wr[nwr > 16 ? 15 : nwr - 1] !== 16'(32'hC000 + base + (nwr > 16 ? 15 : nwr - 1)))) begin
            errors++; $display("FAIL ar_data: got first=%h expected %h", wr[0], 16'(32'hC000 + base));
        end
        checks++;
        if ({frame_cnt, overflow, timeout_err} !== {2'd3, 2'b00}) begin
            errors++; $display("FAIL ar_status: got frame_cnt=%0d ovf=%b to=%b expected 3 0 0", frame_cnt, overflow, timeout_err);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_overflow();
        test_timeout();
        test_abort();
        test_drain();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
